demux32_stream2: RTL and testbench
==================================

# demux32_stream2

32-bit one-input, two-output stream demultiplexer: steers each accepted input word to output channel 0 or 1 under a per-word select bit, the inverse of the 32-bit 2:1 datapath mux. Each output channel has a one-entry registered buffer with valid/ready handshake and a per-channel delivered-word counter. It sits between an ALU result stage and two downstream consumers, such as the register writeback and the status/flag path.

## Interface
- WIDTH, 32, data word width
- CNT_W, 8, width of each delivered-word counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  input word
- in_ctl  in  1  destination select; 0 → channel 0, 1 → channel 1 (sampled with in_data)
- out0_valid  out  1  channel 0 word present
- out0_ready  in  1  channel 0 consumer accepts
- out0_data  out  WIDTH  channel 0 word
- out1_valid  out  1  channel 1 word present
- out1_ready  in  1  channel 1 consumer accepts
- out1_data  out  WIDTH  channel 1 word
- cnt_clr  in  1  synchronous clear of both counters
- cnt0  out  CNT_W  words delivered on channel 0
- cnt1  out  CNT_W  words delivered on channel 1

## Operation
- Handshake on every port: transfer occurs on a rising edge where valid && ready are both 1.
- Each channel k holds state {outk_valid, outk_data}; buffer is full when outk_valid = 1.
- in_ready = !outS_valid || outS_ready, where S = in_ctl. This is combinational from in_ctl, out0/1_valid and out0/1_ready. in_ready does not depend on in_valid.
- Input accept (in_valid && in_ready): outS_data ← in_data, outS_valid ← 1. The other channel's buffer is untouched.
- Output drain (outk_valid && outk_ready) with no refill of channel k that cycle: outk_valid ← 0. outk_data is held (don't-care once invalid).
- Same-cycle drain and refill of a channel: new word is loaded and valid stays 1, giving full throughput of 1 word/cycle per channel.
- Head-of-line blocking: if the selected channel is full and not draining, in_ready = 0, even when the other channel is empty.
- Words on each channel leave in the order accepted. No ordering holds between channels.
- While outk_valid && !outk_ready, outk_data is stable.
- Counters: cntk increments by 1 on each channel k output transfer and wraps modulo 2^CNT_W (255 → 0 at default).
- cnt_clr = 1: both counters go to 0. If a transfer on channel k coincides with cnt_clr, cntk ← 1 so the event is not lost.
- An input arriving while in_valid = 0, with in_ctl or in_data changing, causes no state change.

## Timing
- Reset (rst_n = 0, asynchronous): out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0. in_ready = 1 during and after reset, since both buffers are empty.
- Reset asserted mid-operation: buffered words are discarded and counters are zeroed immediately, without waiting for clk.
- Latency: a word accepted on edge N is presented on outS_valid/outS_data after edge N. The earliest consumer transfer is edge N+1.
- The counter updates on the same edge as the output transfer and is visible after that edge.
- Sustained throughput is 1 word/cycle when the consumer of the selected channel holds ready = 1. Bubbles occur only from back-pressure.
- Combinational paths run from in_ctl and outk_ready to in_ready. No combinational path runs from in_data to any output.

## Test plan
- Reset, then alternate in_ctl 0,1,0,1 with data 0x00000001..0x00000004 and both readies held at 1. Expected: out0 sees 0x1 then 0x3, out1 sees 0x2 then 0x4, each 1 cycle after accept, cnt0 = cnt1 = 2.
- out0_ready = 0, send 0xDEADBEEF to ch0, then 0xCAFEF00D to ch0. Expected: first word is held stable and in_ready = 0 for the second word. An in_ctl = 1 word 0x12345678 still stalls, because it is behind the held word in the input stream (head-of-line). Raise out0_ready: both ch0 words drain in order.
- Back-to-back streaming of 300 words to ch1 with out1_ready = 1 every cycle. Expected: no bubbles, in_ready is constantly 1, and cnt1 wraps to 300 − 256 = 44.
- cnt_clr pulsed on the same edge as a ch0 transfer, with cnt0 = 7 beforehand. Expected: cnt0 = 1 and cnt1 = 0 after that edge.
- Assert rst_n = 0 between clock edges while both buffers are full (0xAAAAAAAA and 0x55555555). Expected: out0_valid and out1_valid drop to 0 immediately, data and counters read 0, and in_ready = 1.
- Toggle in_data/in_ctl with in_valid = 0 for 10 cycles. Expected: no output valids and both counters unchanged.

Source files
------------

// File: rtl/demux32_stream2.sv
// demux32_stream2
// One-input, two-output stream demultiplexer. Each accepted input word is
// steered to channel 0 or 1 by in_ctl. Each channel has a one-entry registered
// buffer and a counter of delivered words.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input stream handshake and word
//   in_ctl                      destination channel, sampled with in_data
//   out0_valid/ready/data       channel 0 output stream
//   out1_valid/ready/data       channel 1 output stream
//   cnt_clr                     synchronous clear of both delivered-word counters
//   cnt0, cnt1                  words delivered on channel 0 / channel 1
module demux32_stream2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ctl,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic space0, space1;
  logic load0, load1;
  logic xfer0, xfer1;
  logic accept;

  // A channel can take a word when empty or when it drains on this edge.
  // Only the selected channel matters, so a stalled word blocks the stream
  // even if the other channel is idle.
  assign space0   = !out0_valid || out0_ready;
  assign space1   = !out1_valid || out1_ready;
  assign in_ready = in_ctl ? space1 : space0;

  assign accept = in_valid && in_ready;
  assign load0  = accept && !in_ctl;
  assign load1  = accept &&  in_ctl;
  assign xfer0  = out0_valid && out0_ready;
  assign xfer1  = out1_valid && out1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (xfer0) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (xfer1) begin
      out1_valid <= 1'b0;
    end
  end

  // A transfer coinciding with a clear is counted as the first word after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (cnt_clr) begin
        cnt0 <= xfer0 ? CNT_ONE : '0;
        cnt1 <= xfer1 ? CNT_ONE : '0;
      end else begin
        if (xfer0) cnt0 <= cnt0 + CNT_ONE;
        if (xfer1) cnt1 <= cnt1 + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_demux32_stream2.sv
module tb_demux32_stream2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_ctl;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic        cnt_clr;
  logic [7:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [7:0]  mc0 = 8'd0;
  logic [7:0]  mc1 = 8'd0;

  demux32_stream2 #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctl(in_ctl),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: words are pushed when the bench sees an accept coming on the
  // next edge, popped when the matching channel transfer is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mc0 = 8'd0;
      mc1 = 8'd0;
    end else begin
      check("cnt0_model", {24'd0, cnt0}, {24'd0, mc0});
      check("cnt1_model", {24'd0, cnt1}, {24'd0, mc1});
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("q0_underflow", {31'd0, out0_valid}, 32'd0);
        else check("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("q1_underflow", {31'd0, out1_valid}, 32'd0);
        else check("out1_data", out1_data, q1.pop_front());
      end
      if (cnt_clr) begin
        mc0 = (out0_valid && out0_ready) ? 8'd1 : 8'd0;
        mc1 = (out1_valid && out1_ready) ? 8'd1 : 8'd0;
      end else begin
        if (out0_valid && out0_ready) mc0 = mc0 + 8'd1;
        if (out1_valid && out1_ready) mc1 = mc1 + 8'd1;
      end
      if (in_valid && in_ready) begin
        if (in_ctl) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  // Drive one word, wait (bounded) for acceptance, then confirm it landed
  // in the selected buffer right after the accepting edge.
  task automatic send(input logic [31:0] d, input logic c, output int stalls);
    in_valid = 1'b1;
    in_data  = d;
    in_ctl   = c;
    stalls   = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (c) begin
      check("out1_valid_after_accept", {31'd0, out1_valid}, 32'd1);
      check("out1_data_after_accept", out1_data, d);
    end else begin
      check("out0_valid_after_accept", {31'd0, out0_valid}, 32'd1);
      check("out0_data_after_accept", out0_data, d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!out0_valid && !out1_valid) break;
    end
    check("drain", {30'd0, out0_valid, out1_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int bubbles;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctl = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1; cnt_clr = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
    check("rst_data0", out0_data, 32'd0);
    check("rst_data1", out1_data, 32'd0);
    check("rst_cnts", {cnt0, cnt1}, 32'd0);
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();

    // Alternating channels, both consumers ready
    for (int i = 1; i <= 4; i++) send(32'(i), ((i % 2) == 0), st);
    drain();
    check("alt_cnt0", {24'd0, cnt0}, 32'd2);
    check("alt_cnt1", {24'd0, cnt1}, 32'd2);

    // Back-pressure on channel 0 and head-of-line blocking
    out0_ready = 1'b0;
    send(32'hDEADBEEF, 1'b0, st);
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_ctl = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hol_in_ready", {31'd0, in_ready}, 32'd0);
      check("hol_hold_valid", {31'd0, out0_valid}, 32'd1);
      check("hol_hold_data", out0_data, 32'hDEADBEEF);
      check("hol_ch1_idle", {31'd0, out1_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    send(32'hCAFEF00D, 1'b0, st);
    check("refill_no_stall", 32'(st), 32'd0);
    send(32'h12345678, 1'b1, st);
    drain();
    check("hol_cnt0", {24'd0, cnt0}, 32'd4);
    check("hol_cnt1", {24'd0, cnt1}, 32'd3);

    // Clear with no transfer in flight
    cnt_clr = 1'b1;
    idle_cycle();
    cnt_clr = 1'b0;
    check("clr_idle", {cnt0, cnt1}, 32'd0);

    // 300 words streamed to channel 1
    bubbles = 0;
    for (int i = 0; i < 300; i++) begin
      send(32'h1000_0000 + 32'(i), 1'b1, st);
      bubbles += st;
    end
    drain();
    check("stream_bubbles", 32'(bubbles), 32'd0);
    check("stream_cnt1_wrap", {24'd0, cnt1}, 32'd44);

    // Clear coinciding with a channel 0 transfer
    for (int i = 0; i < 7; i++) send(32'h2000_0000 + 32'(i), 1'b0, st);
    drain();
    check("pre_clr_cnt0", {24'd0, cnt0}, 32'd7);
    out0_ready = 1'b0;
    send(32'h0BADF00D, 1'b0, st);
    cnt_clr = 1'b1;
    out0_ready = 1'b1;
    idle_cycle();
    cnt_clr = 1'b0;
    check("clr_xfer_cnt0", {24'd0, cnt0}, 32'd1);
    check("clr_xfer_cnt1", {24'd0, cnt1}, 32'd0);
    drain();

    // Asynchronous reset with both buffers full
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(32'hAAAAAAAA, 1'b0, st);
    send(32'h55555555, 1'b1, st);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
    check("arst_data0", out0_data, 32'd0);
    check("arst_data1", out1_data, 32'd0);
    check("arst_cnts", {cnt0, cnt1}, 32'd0);
    in_ctl = 1'b0;
    #1;
    check("arst_in_ready0", {31'd0, in_ready}, 32'd1);
    in_ctl = 1'b1;
    #1;
    check("arst_in_ready1", {31'd0, in_ready}, 32'd1);
    idle_cycle();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle_cycle();

    // Input activity without in_valid must not change state
    send(32'h0000_00A5, 1'b1, st);
    drain();
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      in_ctl  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("novalid_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("novalid_cnt0", {24'd0, cnt0}, 32'd0);
    check("novalid_cnt1", {24'd0, cnt1}, 32'd1);
    check("sb_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
